// File: rtl/vga_sync_gen_if.sv
// Video timing bundle from vga_sync_gen to downstream renderers.
// master drives the timing, slave consumes it.
interface vga_sync_gen_if;
   logic        pix_tick;
   logic [10:0] pix_x;
   logic [10:0] pix_y;
   logic        video_on;
   logic        hsync;
   logic        vsync;
   logic        line_tick;
   logic        frame_tick;

   modport master (
      output pix_tick, pix_x, pix_y, video_on, hsync, vsync, line_tick, frame_tick
   );

   modport slave (
      input  pix_tick, pix_x, pix_y, video_on, hsync, vsync, line_tick, frame_tick
   );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, h/v counters, registered syncs,
// video_on and line/frame strobes aligned with the pix_x/pix_y they describe.
module vga_sync_gen #(
   parameter int H_DISPLAY = 800,
   parameter int H_FRONT   = 56,
   parameter int H_SYNC    = 120,
   parameter int H_BACK    = 64,
   parameter int V_DISPLAY = 600,
   parameter int V_FRONT   = 37,
   parameter int V_SYNC    = 6,
   parameter int V_BACK    = 23,
   parameter int SYNC_POL  = 1,
   parameter int CLK_DIV   = 1
) (
   input logic            clk,
   input logic            reset,
   vga_sync_gen_if.master vga
);

   localparam logic [10:0] H_LAST   = 11'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
   localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [10:0] V_LAST   = 11'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
   localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic [2:0]  DIV_LAST = 3'(CLK_DIV - 1);
   localparam logic        POL      = (SYNC_POL != 0);

   logic [2:0]  r_div_cnt;
   logic [10:0] r_h_cnt;
   logic [10:0] r_v_cnt;
   logic        r_video_on;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_line_tick;
   logic        r_frame_tick;

   logic        w_tick;
   logic        w_h_wrap;
   logic        w_v_wrap;
   logic [10:0] w_h_next;
   logic [10:0] w_v_next;

   always_comb begin
      w_tick   = (r_div_cnt == DIV_LAST);
      w_h_wrap = (r_h_cnt == H_LAST);
      w_v_wrap = (r_v_cnt == V_LAST);
      w_h_next = w_h_wrap ? '0 : r_h_cnt + 11'd1;
      w_v_next = r_v_cnt;
      if (w_h_wrap) begin
         w_v_next = w_v_wrap ? '0 : r_v_cnt + 11'd1;
      end
   end

   // Syncs and video_on are decoded from the next counter values so that,
   // once registered, they line up with the counters loaded on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div_cnt    <= '0;
         r_h_cnt      <= '0;
         r_v_cnt      <= '0;
         r_video_on   <= 1'b1;
         r_hsync      <= ~POL;
         r_vsync      <= ~POL;
         r_line_tick  <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_div_cnt    <= w_tick ? '0 : r_div_cnt + 3'd1;
         r_line_tick  <= w_tick & w_h_wrap;
         r_frame_tick <= w_tick & w_h_wrap & w_v_wrap;
         if (w_tick) begin
            r_h_cnt    <= w_h_next;
            r_v_cnt    <= w_v_next;
            r_video_on <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
            r_hsync    <= ((w_h_next >= HS_START) && (w_h_next <= HS_END)) ? POL : ~POL;
            r_vsync    <= ((w_v_next >= VS_START) && (w_v_next <= VS_END)) ? POL : ~POL;
         end
      end
   end

   assign vga.pix_tick   = w_tick;
   assign vga.pix_x      = r_h_cnt;
   assign vga.pix_y      = r_v_cnt;
   assign vga.video_on   = r_video_on;
   assign vga.hsync      = r_hsync;
   assign vga.vsync      = r_vsync;
   assign vga.line_tick  = r_line_tick;
   assign vga.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing, CLK_DIV=2, and a reduced
// negative-polarity timing small enough to run whole frames.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_def;
   logic rst_div;
   logic rst_sm;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   vga_sync_gen_if vd ();
   vga_sync_gen_if v2 ();
   vga_sync_gen_if vs ();

   vga_sync_gen u_def (
      .clk   (clk),
      .reset (rst_def),
      .vga   (vd)
   );

   vga_sync_gen #(
      .CLK_DIV (2)
   ) u_div2 (
      .clk   (clk),
      .reset (rst_div),
      .vga   (v2)
   );

   // Small timing: H_TOTAL=25 (hsync 18..21), V_TOTAL=17 (vsync 12..14), active-low syncs
   vga_sync_gen #(
      .H_DISPLAY (16),
      .H_FRONT   (2),
      .H_SYNC    (4),
      .H_BACK    (3),
      .V_DISPLAY (10),
      .V_FRONT   (2),
      .V_SYNC    (3),
      .V_BACK    (2),
      .SYNC_POL  (0),
      .CLK_DIV   (1)
   ) u_sm (
      .clk   (clk),
      .reset (rst_sm),
      .vga   (vs)
   );

   task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ex, ey;
      int n_lt, n_hs, n_ft, n_win, n_bad;
      int hs_rise, hs_fall, vo_fall;
      logic prev_hs, prev_vo;

      rst_def = 1'b1;
      rst_div = 1'b1;
      rst_sm  = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check_val("rst_x",        vd.pix_x, 0);
      check_val("rst_y",        vd.pix_y, 0);
      check_val("rst_video_on", vd.video_on, 1);
      check_val("rst_hsync",    vd.hsync, 0);
      check_val("rst_vsync",    vd.vsync, 0);
      check_val("rst_line",     vd.line_tick, 0);
      check_val("rst_frame",    vd.frame_tick, 0);
      check_val("rst_tick_d1",  vd.pix_tick, 1);
      check_val("rst_tick_d2",  v2.pix_tick, 0);
      check_val("rst_sm_hsync", vs.hsync, 1);
      check_val("rst_sm_vsync", vs.vsync, 1);
      check_val("rst_sm_video", vs.video_on, 1);

      // Default timing: first line plus the wrap into line 1
      rst_def = 1'b0;
      check_val("rel_x0", vd.pix_x, 0);
      check_val("rel_y0", vd.pix_y, 0);
      n_lt = 0; n_hs = 0; hs_rise = -1; hs_fall = -1; vo_fall = -1;
      prev_hs = vd.hsync; prev_vo = vd.video_on;
      for (int k = 1; k <= 1045; k++) begin
         @(negedge clk);
         ex = k % 1040;
         ey = k / 1040;
         check_val("def_x",     vd.pix_x, ex);
         check_val("def_y",     vd.pix_y, ey);
         check_val("def_video", vd.video_on, (ex < 800) ? 1 : 0);
         check_val("def_hsync", vd.hsync, (ex >= 856 && ex <= 975) ? 1 : 0);
         check_val("def_vsync", vd.vsync, 0);
         check_val("def_line",  vd.line_tick, (ex == 0) ? 1 : 0);
         check_val("def_frame", vd.frame_tick, 0);
         if (vd.line_tick) n_lt++;
         if (vd.hsync) n_hs++;
         if (vd.hsync && !prev_hs) hs_rise = int'(vd.pix_x);
         if (!vd.hsync && prev_hs) hs_fall = int'(vd.pix_x);
         if (!vd.video_on && prev_vo && vo_fall < 0) vo_fall = int'(vd.pix_x);
         prev_hs = vd.hsync;
         prev_vo = vd.video_on;
      end
      check_val("def_line_count",  n_lt, 1);
      check_val("def_hsync_width", n_hs, 120);
      check_val("def_hsync_rise",  hs_rise, 856);
      check_val("def_hsync_fall",  hs_fall, 976);
      check_val("def_video_fall",  vo_fall, 800);

      // Asynchronous reset while hsync is active
      for (int i = 0; i < 2000 && vd.pix_x != 11'd900; i++) @(negedge clk);
      check_val("def_wait900_x", vd.pix_x, 900);
      check_val("def_wait900_y", vd.pix_y, 1);
      check_val("def_wait900_hs", vd.hsync, 1);
      rst_def = 1'b1;
      #1;
      check_val("arst_x",     vd.pix_x, 0);
      check_val("arst_y",     vd.pix_y, 0);
      check_val("arst_hsync", vd.hsync, 0);
      check_val("arst_video", vd.video_on, 1);
      repeat (3) @(negedge clk);
      check_val("arst_hold_x", vd.pix_x, 0);
      rst_def = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         check_val("arst_rel_x",     vd.pix_x, k);
         check_val("arst_rel_y",     vd.pix_y, 0);
         check_val("arst_rel_line",  vd.line_tick, 0);
         check_val("arst_rel_frame", vd.frame_tick, 0);
      end

      // CLK_DIV=2: one line takes 2080 clks
      rst_div = 1'b0;
      n_lt = 0;
      for (int k = 0; k <= 2085; k++) begin
         if (k > 0) @(negedge clk);
         ex = (k / 2) % 1040;
         ey = k / 2080;
         check_val("d2_tick",  v2.pix_tick, (k % 2 == 1) ? 1 : 0);
         check_val("d2_x",     v2.pix_x, ex);
         check_val("d2_y",     v2.pix_y, ey);
         check_val("d2_video", v2.video_on, (ex < 800) ? 1 : 0);
         check_val("d2_hsync", v2.hsync, (ex >= 856 && ex <= 975) ? 1 : 0);
         check_val("d2_line",  v2.line_tick, (k > 0 && k % 2 == 0 && ex == 0) ? 1 : 0);
         if (v2.line_tick) n_lt++;
      end
      check_val("d2_line_count", n_lt, 1);

      // Small timing: two full frames
      rst_sm = 1'b0;
      n_ft = 0; n_win = 0; n_bad = 0;
      for (int k = 0; k <= 2 * 425; k++) begin
         if (k > 0) @(negedge clk);
         ex = k % 25;
         ey = (k / 25) % 17;
         check_val("sm_x",     vs.pix_x, ex);
         check_val("sm_y",     vs.pix_y, ey);
         check_val("sm_video", vs.video_on, (ex < 16 && ey < 10) ? 1 : 0);
         check_val("sm_hsync", vs.hsync, (ex >= 18 && ex <= 21) ? 0 : 1);
         check_val("sm_vsync", vs.vsync, (ey >= 12 && ey <= 14) ? 0 : 1);
         check_val("sm_line",  vs.line_tick, (k > 0 && ex == 0) ? 1 : 0);
         check_val("sm_frame", vs.frame_tick, (k > 0 && ex == 0 && ey == 0) ? 1 : 0);
         if (vs.frame_tick) n_ft++;
         if (k >= 1 && k <= 425 && vs.video_on &&
             vs.pix_x >= 11'd4 && vs.pix_x <= 11'd11 &&
             vs.pix_y >= 11'd2 && vs.pix_y <= 11'd7) n_win++;
         if (vs.video_on && (!vs.hsync || !vs.vsync)) n_bad++;
      end
      check_val("sm_frame_count", n_ft, 2);
      check_val("sm_window_px",   n_win, 48);
      check_val("sm_sync_in_vis", n_bad, 0);

      // Asynchronous reset inside both sync windows
      for (int i = 0; i < 500 && !(vs.pix_x == 11'd19 && vs.pix_y == 11'd13); i++) @(negedge clk);
      check_val("sm_wait_x",  vs.pix_x, 19);
      check_val("sm_wait_y",  vs.pix_y, 13);
      check_val("sm_wait_hs", vs.hsync, 0);
      check_val("sm_wait_vs", vs.vsync, 0);
      rst_sm = 1'b1;
      #1;
      check_val("sm_arst_x",     vs.pix_x, 0);
      check_val("sm_arst_y",     vs.pix_y, 0);
      check_val("sm_arst_hsync", vs.hsync, 1);
      check_val("sm_arst_vsync", vs.vsync, 1);
      check_val("sm_arst_video", vs.video_on, 1);
      repeat (3) @(negedge clk);
      rst_sm = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         check_val("sm_rel_x",     vs.pix_x, k);
         check_val("sm_rel_line",  vs.line_tick, 0);
         check_val("sm_rel_frame", vs.frame_tick, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
